axi_lite_master: RTL

- Bridges a simple single-outstanding command port (req/ack style) to an AXI4-Lite master interface.
- Sits directly upstream of AXI_INTERFACE_GPIO and drives its AW/W/B/AR/R channels.
- Lets a controller or testbench FSM program the GPIO MODER/ODR registers and read IDR without hand-sequencing handshakes.
- Issues one transaction at a time and returns read data and response status.

---
 rtl/axi_lite_master_pkg.sv | 25 ++
 rtl/axi_lite_master_if.sv | 46 ++++
 rtl/axi_lite_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Holds the FSM state encoding, AXI response codes and the GPIO register map.
package axi_lite_pkg;

  localparam int unsigned RESP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4
  } state_e;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  // GPIO slave register byte offsets
  localparam logic [3:0] MODER = 4'h0;
  localparam logic [3:0] ODR   = 4'h4;
  localparam logic [3:0] IDR   = 4'h8;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite channel bundle between the command master and a lite slave.
interface axi_lite_master_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;

  logic [RESP_W-1:0] BRESP;
  logic              BVALID;
  logic              BREADY;

  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;

  logic [DATA_W-1:0] RDATA;
  logic [RESP_W-1:0] RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA,  WVALID,  input WREADY,
    input  BRESP,  BVALID,  output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA,  RRESP,   RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA,  WVALID,  output WREADY,
    output BRESP,  BVALID,  input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA,  RRESP,   RVALID, input RREADY
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding req/ack command port bridged onto an AXI4-Lite master.
// Every output, including all AXI VALID/READY, comes straight from a flop.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               cmd_req,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               cmd_ready,
  output logic               cmd_done,
  output logic [DATA_W-1:0]  cmd_rdata,
  output logic [RESP_W-1:0]  cmd_resp,
  axi_lite_master_if.master  m_axi
);

  state_e            r_state;
  logic              r_cmd_ready;
  logic              r_cmd_done;
  logic [DATA_W-1:0] r_cmd_rdata;
  logic [RESP_W-1:0] r_cmd_resp;

  logic [ADDR_W-1:0] r_awaddr;
  logic              r_awvalid;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wvalid;
  logic              r_bready;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;

  logic              r_aw_done;
  logic              r_w_done;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_fin;
  logic              w_w_fin;

  // A channel counts as finished if it handshook earlier or is handshaking now
  assign w_aw_hs  = r_awvalid & m_axi.AWREADY;
  assign w_w_hs   = r_wvalid  & m_axi.WREADY;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done  | w_w_hs;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_cmd_done  <= 1'b0;
      r_cmd_rdata <= '0;
      r_cmd_resp  <= RESP_OKAY;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_req) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_ADDR_DATA;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end

        ST_WR_ADDR_DATA: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WR_RESP;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end

        ST_WR_RESP: begin
          if (m_axi.BVALID) begin
            r_cmd_resp  <= m_axi.BRESP;
            r_bready    <= 1'b0;
            r_cmd_done  <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (m_axi.RVALID) begin
            r_cmd_rdata <= m_axi.RDATA;
            r_cmd_resp  <= m_axi.RRESP;
            r_rready    <= 1'b0;
            r_cmd_done  <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign cmd_done      = r_cmd_done;
  assign cmd_rdata     = r_cmd_rdata;
  assign cmd_resp      = r_cmd_resp;

  assign m_axi.AWADDR  = r_awaddr;
  assign m_axi.AWVALID = r_awvalid;
  assign m_axi.WDATA   = r_wdata;
  assign m_axi.WVALID  = r_wvalid;
  assign m_axi.BREADY  = r_bready;
  assign m_axi.ARADDR  = r_araddr;
  assign m_axi.ARVALID = r_arvalid;
  assign m_axi.RREADY  = r_rready;

endmodule
